// File: rtl/fifo8b_if.sv
// Byte FIFO bus: producer write side, consumer read side, and the status flags.
// The FIFO itself uses the slave modport; the surrounding logic uses master.
interface fifo8b_if #(
  parameter int AW = 3
);
  logic [7:0]  I;
  logic        WE;
  logic        RE;
  logic [7:0]  O;
  logic        EMPTY;
  logic        FULL;
  logic [AW:0] CNT;
  logic        OVF;
  logic        UDF;

  modport slave (
    input  I, WE, RE,
    output O, EMPTY, FULL, CNT, OVF, UDF
  );

  modport master (
    output I, WE, RE,
    input  O, EMPTY, FULL, CNT, OVF, UDF
  );
endinterface

// File: rtl/fifo8b.sv
// Synchronous first-word-fall-through byte FIFO; a write into an empty FIFO shows on O one cycle later.
// No backpressure: a write while FULL or a read while EMPTY is dropped and flagged for one cycle on OVF/UDF.
module fifo8b #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic    CLK,
  input  logic    RSTN,
  fifo8b_if.slave bus
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 256) begin : g_param_chk
    $error("fifo8b: DEPTH must be a power of two in 2..256 and equal 2**AW");
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance looks only at registered flags, so a full FIFO never writes through on a same-cycle pop.
  always_comb begin
    wr_acc  = bus.WE && !full_q;
    rd_acc  = bus.RE && !empty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (wr_acc) wptr_d = wptr_q + AW'(1);
    if (rd_acc) rptr_d = rptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == DEPTH_C);
    ovf_d   = bus.WE && full_q;
    udf_d   = bus.RE && empty_q;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately left uncleared; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (RSTN && wr_acc) begin
      mem_q[wptr_q] <= bus.I;
    end
  end

  assign bus.O     = empty_q ? 8'h00 : mem_q[rptr_q];
  assign bus.EMPTY = empty_q;
  assign bus.FULL  = full_q;
  assign bus.CNT   = cnt_q;
  assign bus.OVF   = ovf_q;
  assign bus.UDF   = udf_q;

endmodule

// File: doc/fifo8b.md
Name: fifo8b

Overview:
- 8-bit synchronous byte FIFO with first-word-fall-through output.
- Sits directly upstream of the 8-bit buffer stage and feeds its input bus.
- Decouples a bursty byte producer from the buffered 8-bit consumer path.
- Flags full/empty, exposes occupancy, and reports overflow/underflow attempts.

Parameters:
DEPTH, 8, number of byte entries; power of two, legal range 2..256.
AW, 3, pointer width; must equal log2(DEPTH).

Ports:
CLK  input  1  rising-edge clock; the only clock.
RSTN  input  1  synchronous active-low reset.
I  input  8  write data byte.
WE  input  1  write request; sampled on the CLK rising edge.
RE  input  1  read (pop) request; sampled on the CLK rising edge.
O  output  8  head byte; drives the downstream 8-bit buffer input.
EMPTY  output  1  1 = no entries held.
FULL  output  1  1 = DEPTH entries held.
CNT  output  AW+1  current occupancy, 0..DEPTH.
OVF  output  1  one-cycle pulse: a write was rejected because the FIFO was full.
UDF  output  1  one-cycle pulse: a read was rejected because the FIFO was empty.

Behaviour:
- Clocking: single clock CLK; reset is synchronous and active-low on RSTN. RSTN=0 at a rising edge gives: write pointer=0, read pointer=0, CNT=0, EMPTY=1, FULL=0, OVF=0, UDF=0, O=8'h00. Storage array contents are not cleared. Reset wins over any simultaneous WE/RE, including mid-burst; all held data is discarded.
- Accepted write: WE=1 and FULL=0 at an edge. I is stored at the write pointer, and the write pointer advances modulo DEPTH (wraps DEPTH-1 -> 0).
- Accepted read: RE=1 and EMPTY=0 at an edge. The head entry is discarded, and the read pointer advances modulo DEPTH.
- Flags and count: FULL, EMPTY and CNT are registered and update on the same edge as the pointers.
  - Only a write accepted: CNT+1.
  - Only a read accepted: CNT-1.
  - Both accepted: CNT unchanged.
  - EMPTY = (CNT==0). FULL = (CNT==DEPTH).
- Simultaneous WE=1, RE=1:
  - 0<CNT<DEPTH: both accepted.
  - CNT=0: write accepted, read rejected, UDF pulses.
  - CNT=DEPTH: read accepted, write rejected, OVF pulses. No write-through on full, because FULL is evaluated before the read.
- O (first-word-fall-through):
  - When EMPTY=0, O equals the entry at the read pointer. When EMPTY=1, O=8'h00.
  - A byte written into an empty FIFO appears on O one cycle after the write edge (latency 1), coincident with EMPTY falling.
  - After an accepted read, O shows the next entry in the same cycle the pointer advances, or 8'h00 if the FIFO is now empty.
- OVF/UDF: registered, high for exactly one cycle following the rejecting edge, 0 otherwise. Back-to-back rejected requests give OVF/UDF held high for consecutive cycles. A rejected request leaves pointers, CNT, flags and storage unchanged.
- Ordering: strict first-in first-out. No data is lost or duplicated across pointer wrap.
- No combinational path from WE/RE/I to any output. All outputs are register-driven or a mux of registers.

Test Plan:
- Reset: hold RSTN=0 for 2 edges with WE=1, I=8'hFF -> CNT=0, EMPTY=1, FULL=0, O=8'h00, OVF=UDF=0. Deassert RSTN with WE=0 -> outputs stay at those values.
- Fill/drain: write 8'h11..8'h88 on 8 consecutive edges -> O=8'h11 one cycle after the first write, FULL=1 and CNT=8 after the 8th. Then RE=1 for 8 edges -> O steps 8'h22..8'h88, then 8'h00, EMPTY=1, CNT=0.
- Overflow: when FULL, WE=1 with I=8'hAA, RE=0 -> OVF=1 for one cycle, CNT stays 8, 8'hAA never appears on O during a full drain. When full, WE=RE=1 -> one pop, CNT=7, OVF=1.
- Underflow and simultaneous on empty: RE=1 alone on empty -> UDF=1 for one cycle, state unchanged. WE=RE=1 with I=8'h5C on empty -> UDF=1, CNT=1, O=8'h5C next cycle.
- Wrap-around: 20 cycles of WE=RE=1 at CNT=3 with incrementing data -> CNT constant at 3, O sequence exactly matches the input delayed by 3 pops across pointer wrap, no OVF/UDF.
- Reset mid-operation: with CNT=5, pulse RSTN=0 for one edge while WE=RE=1 -> CNT=0, EMPTY=1, O=8'h00. The next write of 8'h3E appears on O one cycle later.
